// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller in front of the CPU's
// interrupt_i[5:0] input, and a slave on the data-RAM bus.
//
// Parameters:
//   NUM_SRC    number of external sources (1..8)
//   BASE_ADDR  base of the 32-byte register window (32-byte aligned)
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   src_i           raw interrupt sources
//   timer_int_i     CP0 timer interrupt, merged onto interrupt_o[5]
//   ce_i, we_i      bus chip enable / write enable
//   addr_i, sel_i   byte address / write byte enables
//   data_i, data_o  write data / combinational read data
//   interrupt_o     registered interrupt lines to the CPU
// Build option:
//   IRQ_SYNC_EN     when defined, src_i passes through a 2-flop synchroniser;
//                   otherwise src_i is assumed synchronous to clk.
// Register window (word offsets):
//   0 PENDING (W1C, edge sources)  1 ENABLE  2 EDGE  3 ROUTE (3 bits/source)
//   4 RAW (read-only)              5..7 reserved, read 0
module irq_ctrl #(
    parameter int          NUM_SRC   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               timer_int_i,
    input  logic               ce_i,
    input  logic               we_i,
    input  logic [31:0]        addr_i,
    input  logic [3:0]         sel_i,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o,
    output logic [5:0]         interrupt_o
);

    localparam int RW = 3 * NUM_SRC;

    logic               hit;
    logic               wr;
    logic [2:0]         offset;
    logic [31:0]        bmask;
    logic [NUM_SRC-1:0] pend, enable, edge_mode;
    logic [NUM_SRC-1:0] s, prev, clr, pend_next;
    logic [RW-1:0]      route;
    logic [5:0]         irq_next;

    // Address bits [1:0] and data/sel bits beyond the register widths are
    // intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{addr_i[1:0], data_i, sel_i};

    assign hit    = ce_i && (addr_i[31:5] == BASE_ADDR[31:5]);
    assign wr     = hit && we_i;
    assign offset = addr_i[4:2];
    assign bmask  = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};

    // ---------------- source synchronisation ----------------
`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1, sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= src_i;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = src_i;
`endif

    // ---------------- pending logic ----------------
    // Clear bits only count inside enabled byte lanes of a PENDING write.
    assign clr = (wr && offset == 3'd0) ? (data_i[NUM_SRC-1:0] & bmask[NUM_SRC-1:0])
                                        : '0;

    // Edge sources: a new rising edge wins over a simultaneous W1C.
    // Level sources simply track s and ignore W1C.
    assign pend_next = (edge_mode & ((pend & ~clr) | (s & ~prev)))
                     | (~edge_mode & s);

    // ---------------- routing ----------------
    always_comb begin
        irq_next = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // Route codes 6 and 7 disconnect the source.
            if (pend[i] && enable[i] && route[3*i +: 3] < 3'd6)
                irq_next[route[3*i +: 3]] = 1'b1;
        end
        irq_next[5] = irq_next[5] | timer_int_i;
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend        <= '0;
            prev        <= '0;
            enable      <= '0;
            edge_mode   <= '0;
            route       <= '0;
            interrupt_o <= '0;
        end else begin
            pend        <= pend_next;
            prev        <= s;
            interrupt_o <= irq_next;
            if (wr) begin
                case (offset)
                    3'd1: enable    <= (enable & ~bmask[NUM_SRC-1:0])
                                     | (data_i[NUM_SRC-1:0] & bmask[NUM_SRC-1:0]);
                    3'd2: edge_mode <= (edge_mode & ~bmask[NUM_SRC-1:0])
                                     | (data_i[NUM_SRC-1:0] & bmask[NUM_SRC-1:0]);
                    3'd3: route     <= (route & ~bmask[RW-1:0])
                                     | (data_i[RW-1:0] & bmask[RW-1:0]);
                    default: ;
                endcase
            end
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        data_o = '0;
        if (hit && !we_i) begin
            case (offset)
                3'd0:    data_o = 32'(pend);
                3'd1:    data_o = 32'(enable);
                3'd2:    data_o = 32'(edge_mode);
                3'd3:    data_o = 32'(route);
                3'd4:    data_o = 32'(s);
                default: data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed checks plus randomized bus/source traffic
// compared every cycle against a behavioural model of the register map.
module tb_irq_ctrl;

    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef IRQ_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] src_i;
    logic         timer_int_i;
    logic         ce_i, we_i;
    logic [31:0]  addr_i;
    logic [3:0]   sel_i;
    logic [31:0]  data_i;
    logic [31:0]  data_o;
    logic [5:0]   interrupt_o;

    irq_ctrl #(.NUM_SRC(N), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .src_i(src_i), .timer_int_i(timer_int_i),
        .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i), .sel_i(sel_i),
        .data_i(data_i), .data_o(data_o), .interrupt_o(interrupt_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_pend, m_en, m_edge;
    logic [23:0] m_route;
    logic [5:0]  m_irq;
    logic [7:0]  hist[$];   // src_i value seen at each clock edge, newest last

    function automatic void model_reset();
        m_pend = '0; m_en = '0; m_edge = '0; m_route = '0; m_irq = '0;
        hist.delete();
        repeat (3) hist.push_back(8'h00);
    endfunction

    // Level the pending logic sees right now.
    function automatic logic [7:0] s_now();
        return SYNC ? hist[hist.size()-2] : src_i;
    endfunction

    // Level the pending logic saw one edge ago.
    function automatic logic [7:0] prev_now();
        return SYNC ? hist[hist.size()-3] : hist[hist.size()-1];
    endfunction

    function automatic logic bus_hit();
        return ce_i && (addr_i[31:5] == BASE[31:5]);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) if (sel[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [31:0] model_read();
        if (!bus_hit() || we_i) return 32'h0;
        case (addr_i[4:2])
            3'd0:    return {24'h0, m_pend};
            3'd1:    return {24'h0, m_en};
            3'd2:    return {24'h0, m_edge};
            3'd3:    return {8'h0, m_route};
            3'd4:    return {24'h0, s_now()};
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model across one clock edge using the inputs about to be sampled.
    function automatic void model_edge();
        logic [7:0]  s = s_now();
        logic [7:0]  p = prev_now();
        logic [31:0] m = lane_mask(sel_i);
        logic        w = bus_hit() && we_i;
        logic [7:0]  clr = (w && addr_i[4:2] == 3'd0) ? (data_i[7:0] & m[7:0]) : 8'h0;
        logic [7:0]  np;
        logic [5:0]  ni = '0;
        for (int i = 0; i < N; i++) begin
            int r = (m_route >> (3*i)) & 7;
            if (m_edge[i]) np[i] = (m_pend[i] && !clr[i]) || (s[i] && !p[i]);
            else           np[i] = s[i];
            if (m_pend[i] && m_en[i] && r <= 5) ni[r] = 1'b1;
        end
        if (timer_int_i) ni[5] = 1'b1;
        if (w) begin
            case (addr_i[4:2])
                3'd1: m_en    = (m_en & ~m[7:0])     | (data_i[7:0] & m[7:0]);
                3'd2: m_edge  = (m_edge & ~m[7:0])   | (data_i[7:0] & m[7:0]);
                3'd3: m_route = (m_route & ~m[23:0]) | (data_i[23:0] & m[23:0]);
                default: ;
            endcase
        end
        m_pend = np;
        m_irq  = ni;
        hist.push_back(src_i);
        if (hist.size() > 4) void'(hist.pop_front());
    endfunction

    // ---------------- stimulus helpers ----------------
    // One clock: check read data before the edge, interrupt lines after it.
    task automatic tick();
        #1;
        chk("rdata", data_o, model_read());
        model_edge();
        @(posedge clk);
        #1;
        chk("irq", {26'h0, interrupt_o}, {26'h0, m_irq});
    endtask

    task automatic bus(input logic we, input int off, input logic [3:0] sel, input logic [31:0] d);
        ce_i = 1'b1; we_i = we; addr_i = BASE | (off << 2); sel_i = sel; data_i = d;
    endtask

    task automatic idle();
        ce_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; data_i = '0;
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        bus(1'b1, off, 4'hF, d); tick(); idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_irq", {26'h0, interrupt_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1; src_i = '0; timer_int_i = 1'b0;
        idle();
        model_reset();
        #2;
        chk("por_irq", {26'h0, interrupt_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All offsets read 0 after reset; reserved offsets ignore writes.
        for (int off = 0; off < 8; off++) begin
            bus(1'b0, off, 4'h0, 32'h0);
            tick();
        end
        wr(5, 32'hFFFF_FFFF);
        bus(1'b0, 5, 4'h0, 32'h0); tick(); idle();

        // Edge source 0 routed to line 2.
        wr(2, 32'h01); wr(3, 32'h2); wr(1, 32'h01);
        src_i[0] = 1'b1; repeat (3) tick();
        src_i[0] = 1'b0; repeat (3) tick();
        chk("edge_line2", {26'h0, interrupt_o}, 32'h04);
        bus(1'b0, 0, 4'h0, 32'h0); tick(); idle();
        wr(0, 32'h01); repeat (2) tick();
        chk("w1c_drop", {26'h0, interrupt_o}, 32'h00);

        // Level source 3 on line 5; W1C does not clear it.
        wr(3, 32'h0000_0A02); wr(1, 32'h08);
        src_i[3] = 1'b1; repeat (4) tick();
        wr(0, 32'h08); repeat (2) tick();
        chk("level_hold", {26'h0, interrupt_o}, 32'h20);
        src_i[3] = 1'b0; repeat (4) tick();

        // Timer alone with everything masked.
        wr(1, 32'h00); tick();
        timer_int_i = 1'b1; tick();
        chk("timer", {26'h0, interrupt_o}, 32'h20);
        timer_int_i = 1'b0; tick();

        // Byte-lane write to ROUTE.
        bus(1'b1, 3, 4'b0001, 32'hFFFF_FFFF); tick(); idle();
        bus(1'b0, 3, 4'h0, 32'h0); tick(); idle();

        // Edge source 1: W1C coinciding with a new edge leaves it set.
        wr(2, 32'h02);
        src_i[1] = 1'b1; repeat (4) tick();
        src_i[1] = 1'b0; repeat (2) tick();
        src_i[1] = 1'b1;
        if (SYNC) repeat (2) tick();
        bus(1'b1, 0, 4'hF, 32'h02); tick(); idle();
        bus(1'b0, 0, 4'h0, 32'h0); tick(); idle();
        src_i[1] = 1'b0; tick();

        // Reset with pending set.
        wr(1, 32'hFF); tick();
        do_reset();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            int r = $urandom_range(0, 9);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 2) == 0) src_i[i] = ~src_i[i];
            if ($urandom_range(0, 7) == 0) timer_int_i = ~timer_int_i;
            if (r <= 2) begin
                bus(1'b0, $urandom_range(0, 7), 4'($urandom), 32'h0);
                addr_i[1:0] = 2'($urandom);
            end else if (r <= 5) begin
                bus(1'b1, $urandom_range(0, 3), 4'($urandom), $urandom);
            end else if (r == 6) begin
                bus(1'($urandom), $urandom_range(0, 7), 4'hF, $urandom);
                addr_i[31:5] = addr_i[31:5] + 27'($urandom_range(1, 3));
            end else begin
                idle();
            end
            tick();
            if ($urandom_range(0, 599) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
